// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - register indices, IRQ bit positions and FIFO-window FSM states
package sd_pkg;

  localparam logic [3:0] REG_SCR        = 4'd0;
  localparam logic [3:0] REG_ARG        = 4'd1;
  localparam logic [3:0] REG_CMD        = 4'd2;
  localparam logic [3:0] REG_DAT        = 4'd3;
  localparam logic [3:0] REG_DMA_SCR    = 4'd4;
  localparam logic [3:0] REG_DMA_ADDR   = 4'd5;
  localparam logic [3:0] REG_DMA_LEN    = 4'd6;
  localparam logic [3:0] REG_IRQ_STATUS = 4'd7;
  localparam logic [3:0] REG_IRQ_MASK   = 4'd8;
  localparam logic [3:0] REG_RSP0       = 4'd9;

  localparam int IRQ_CMD_DONE     = 0;
  localparam int IRQ_CMD_TIMEOUT  = 1;
  localparam int IRQ_CMD_CRC      = 2;
  localparam int IRQ_DAT_DONE     = 3;
  localparam int IRQ_DAT_ERR      = 4;
  localparam int IRQ_DMA_DONE     = 5;
  localparam int IRQ_FIFO_TIMEOUT = 6;
  localparam int IRQ_WR_REJECT    = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_WAIT = 2'd1,
    ST_TX_WAIT = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/sd_ctrl_regs_if.sv
// rtl/sd_ctrl_regs_if.sv - CPU register bus between the host and sd_ctrl_regs
interface sd_ctrl_regs_if;
  logic        i_request;
  logic        i_write;
  logic [4:0]  i_address;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_ack;

  modport master (output i_request, i_write, i_address, i_data,
                  input  o_data, o_busy, o_ack);
  modport slave  (input  i_request, i_write, i_address, i_data,
                  output o_data, o_busy, o_ack);
endinterface

// File: rtl/sd_irq_ctrl.sv
// rtl/sd_irq_ctrl.sv - event edge detection, write-1-to-clear latch, mask and irq line
module sd_irq_ctrl
  import sd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cmd_busy,
  input  logic       i_cmd_timeout,
  input  logic       i_cmd_crc,
  input  logic       i_dat_busy,
  input  logic       i_dat_err,
  input  logic       i_dma_busy,
  input  logic       i_fifo_timeout,
  input  logic       i_wr_reject,
  input  logic       i_status_wr,
  input  logic       i_mask_wr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_status,
  output logic [7:0] o_mask,
  output logic       o_irq
);

  // previous samples: {dma_busy, dat_err, dat_busy, cmd_crc, cmd_timeout, cmd_busy}
  logic [5:0] r_prev;
  logic [7:0] r_status;
  logic [7:0] r_mask;
  logic       r_irq;
  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic [7:0] w_status_nxt;
  logic [7:0] w_mask_nxt;

  // busy falling edges mark completion, error flags latch on their rising edge
  always_comb begin
    w_set = '0;
    w_set[IRQ_CMD_DONE]     = r_prev[0] & ~i_cmd_busy;
    w_set[IRQ_CMD_TIMEOUT]  = ~r_prev[1] & i_cmd_timeout;
    w_set[IRQ_CMD_CRC]      = ~r_prev[2] & i_cmd_crc;
    w_set[IRQ_DAT_DONE]     = r_prev[3] & ~i_dat_busy;
    w_set[IRQ_DAT_ERR]      = ~r_prev[4] & i_dat_err;
    w_set[IRQ_DMA_DONE]     = r_prev[5] & ~i_dma_busy;
    w_set[IRQ_FIFO_TIMEOUT] = i_fifo_timeout;
    w_set[IRQ_WR_REJECT]    = i_wr_reject;
    w_clr        = i_status_wr ? i_wdata : 8'h00;
    // set is applied after clear so a coincident event is never lost
    w_status_nxt = (r_status & ~w_clr) | w_set;
    w_mask_nxt   = i_mask_wr ? i_wdata : r_mask;
  end

  // latch status, mask and the irq line computed from their next values
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev   <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= {i_dma_busy, i_dat_err, i_dat_busy, i_cmd_crc, i_cmd_timeout, i_cmd_busy};
      r_status <= w_status_nxt;
      r_mask   <= w_mask_nxt;
      r_irq    <= |(w_status_nxt & w_mask_nxt);
    end
  end

  assign o_status = r_status;
  assign o_mask   = r_mask;
  assign o_irq    = r_irq;

endmodule

// File: rtl/sd_ctrl_regs.sv
// rtl/sd_ctrl_regs.sv - CPU-facing register file for the SD controller
module sd_ctrl_regs
  import sd_pkg::*;
#(
  parameter int RSP_WORDS    = 4,
  parameter int ITEMS_W      = 9,
  parameter int BLK_SIZE_W   = 7,
  parameter int NUM_BLK_W    = 8,
  parameter int DMA_LEN_W    = 15,
  parameter int FIFO_TIMEOUT = 1023
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  sd_ctrl_regs_if.slave                 io_bus,
  output logic                          o_irq,
  output logic [1:0]                    o_sd_clk_config,
  output logic [7:0]                    o_command,
  output logic [31:0]                   o_command_argument,
  output logic                          o_command_start,
  input  logic [8:0]                    i_command_status,
  input  logic [32*RSP_WORDS-1:0]       i_command_response,
  output logic [1+BLK_SIZE_W+NUM_BLK_W:0] o_dat_cfg,
  output logic                          o_dat_start,
  output logic                          o_dat_stop,
  input  logic [4:0]                    i_dat_status,
  output logic [1:0]                    o_fifo_flush,
  output logic                          o_rx_fifo_pop,
  input  logic [ITEMS_W+2:0]            i_rx_fifo_status,
  input  logic [31:0]                   i_rx_fifo_data,
  output logic                          o_tx_fifo_push,
  output logic [31:0]                   o_tx_fifo_data,
  input  logic [ITEMS_W+2:0]            i_tx_fifo_status,
  output logic [27:0]                   o_dma_bank_address,
  output logic [DMA_LEN_W-1:0]          o_dma_length,
  output logic [1:0]                    o_dma_load,
  output logic [2:0]                    o_dma_ctrl,
  input  logic [DMA_LEN_W+28:0]         i_dma_status
);

  localparam int DAT_W = 2 + BLK_SIZE_W + NUM_BLK_W;
  localparam int CNT_W = $clog2(FIFO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIFO_TIMEOUT - 1);

  fifo_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [1:0]           r_clk, r_flush, r_dma_load;
  logic [31:0]          r_arg, r_rdata, r_tx_data;
  logic [7:0]           r_cmd;
  logic [DAT_W-1:0]     r_dat_cfg;
  logic [27:0]          r_dma_addr;
  logic [DMA_LEN_W-1:0] r_dma_len;
  logic                 r_cmd_start, r_dat_start, r_dat_stop;
  logic                 r_dma_dir, r_dma_start, r_dma_stop;
  logic                 r_ack, r_pop, r_push;
  logic [31:0]          w_d, w_rd_mux, w_fifo_rdata;
  logic [3:0]           w_idx;
  logic [7:0]           w_irq_status, w_irq_mask;
  logic                 w_req, w_reg_wr, w_reg_rd, w_cmd_busy, w_dat_busy, w_dma_busy;
  logic                 w_rx_ok, w_tx_ok, w_scr_ok, w_reject;
  logic                 w_pop, w_push, w_fifo_ack, w_fifo_to;

  // requests are only taken while the FIFO window is not stalling the bus
  assign w_req      = io_bus.i_request && (r_state == ST_IDLE);
  assign w_idx      = io_bus.i_address[3:0];
  assign w_d        = io_bus.i_data;
  assign w_reg_wr   = w_req && io_bus.i_write && !io_bus.i_address[4];
  assign w_reg_rd   = w_req && !io_bus.i_write && !io_bus.i_address[4];
  assign w_cmd_busy = i_command_status[6];
  assign w_dat_busy = i_dat_status[0];
  assign w_dma_busy = i_dma_status[DMA_LEN_W+28];
  assign w_rx_ok    = !i_rx_fifo_status[1] && !w_dma_busy;
  assign w_tx_ok    = !i_tx_fifo_status[2] && !w_dma_busy;
  assign w_scr_ok   = !w_cmd_busy && !w_dat_busy;
  assign w_reject   = w_reg_wr && (((w_idx == REG_SCR) && !w_scr_ok) ||
                      (((w_idx == REG_ARG) || (w_idx == REG_CMD)) && w_cmd_busy) ||
                      ((w_idx == REG_DAT) && w_dat_busy && !w_d[31]) ||
                      ((w_idx == REG_DMA_SCR) && w_dma_busy && !w_d[1]));

  // configuration registers and their one-cycle strobes
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_clk <= '0; r_flush <= '0; r_arg <= '0; r_cmd <= '0; r_cmd_start <= 1'b0;
      r_dat_cfg <= '0; r_dat_start <= 1'b0; r_dat_stop <= 1'b0;
      r_dma_dir <= 1'b0; r_dma_start <= 1'b0; r_dma_stop <= 1'b0;
      r_dma_addr <= '0; r_dma_len <= '0; r_dma_load <= '0;
    end else begin
      r_flush <= '0; r_cmd_start <= 1'b0; r_dat_start <= 1'b0; r_dat_stop <= 1'b0;
      r_dma_start <= 1'b0; r_dma_stop <= 1'b0; r_dma_load <= '0;
      if (w_reg_wr) begin
        case (w_idx)
          REG_SCR: begin
            if (w_scr_ok) r_clk <= w_d[1:0];
            r_flush <= w_d[3:2];
          end
          REG_ARG: if (!w_cmd_busy) r_arg <= w_d;
          REG_CMD: if (!w_cmd_busy) begin
            r_cmd       <= {w_d[7], w_d[8], w_d[5:0]};
            r_cmd_start <= 1'b1;
          end
          REG_DAT: if (!w_dat_busy || w_d[31]) begin
            r_dat_cfg   <= w_d[DAT_W-1:0];
            r_dat_start <= w_d[30];
            r_dat_stop  <= w_d[31];
          end
          REG_DMA_SCR: if (!w_dma_busy || w_d[1]) begin
            r_dma_dir   <= w_d[2];
            r_dma_stop  <= w_d[1];
            r_dma_start <= w_d[0];
          end
          REG_DMA_ADDR: begin
            r_dma_addr    <= {w_d[31:28], w_d[25:2]};
            r_dma_load[0] <= 1'b1;
          end
          REG_DMA_LEN: begin
            r_dma_len     <= w_d[DMA_LEN_W-1:0];
            r_dma_load[1] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // register readback multiplexer
  always_comb begin
    w_rd_mux = '0;
    case (w_idx)
      REG_SCR:        w_rd_mux = {11'b0, i_dat_status, i_command_status, 5'b0, r_clk};
      REG_ARG:        w_rd_mux = r_arg;
      REG_CMD:        w_rd_mux = {23'b0, r_cmd[6], r_cmd[7], 1'b0, r_cmd[5:0]};
      REG_DAT:        w_rd_mux = 32'(r_dat_cfg);
      REG_DMA_SCR:    w_rd_mux = {w_dma_busy, 31'({i_tx_fifo_status, i_rx_fifo_status, r_dma_dir, 2'b00})};
      REG_DMA_ADDR:   w_rd_mux = {i_dma_status[DMA_LEN_W+27 -: 4], 2'b0, i_dma_status[DMA_LEN_W+23 -: 24], 2'b0};
      REG_DMA_LEN:    w_rd_mux = 32'(i_dma_status[DMA_LEN_W-1:0]);
      REG_IRQ_STATUS: w_rd_mux = {24'b0, w_irq_status};
      REG_IRQ_MASK:   w_rd_mux = {24'b0, w_irq_mask};
      default: begin
        for (int k = 0; k < RSP_WORDS; k++)
          if (w_idx == 4'(REG_RSP0 + k)) w_rd_mux = i_command_response[32*k +: 32];
      end
    endcase
  end

  // FIFO window state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FIFO window next state: transfer as soon as possible, give up after the stall budget
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    w_fifo_ack   = 1'b0;
    w_fifo_rdata = '0;
    w_fifo_to    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && io_bus.i_address[4]) begin
          if (!io_bus.i_write) begin
            if (w_rx_ok) begin
              w_pop = 1'b1; w_fifo_ack = 1'b1; w_fifo_rdata = i_rx_fifo_data;
            end else w_state_nxt = ST_RX_WAIT;
          end else begin
            if (w_tx_ok) w_push = 1'b1;
            else w_state_nxt = ST_TX_WAIT;
          end
        end
      end
      ST_RX_WAIT: begin
        if (w_rx_ok) begin
          w_pop = 1'b1; w_fifo_ack = 1'b1; w_fifo_rdata = i_rx_fifo_data; w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_fifo_ack = 1'b1; w_fifo_to = 1'b1; w_state_nxt = ST_IDLE;
        end else w_cnt_nxt = r_cnt + 1'b1;
      end
      ST_TX_WAIT: begin
        if (w_tx_ok) begin
          w_push = 1'b1; w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_fifo_to = 1'b1; w_state_nxt = ST_IDLE;
        end else w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // bus completion and FIFO strobes
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ack <= 1'b0; r_rdata <= '0; r_pop <= 1'b0; r_push <= 1'b0; r_tx_data <= '0;
    end else begin
      r_ack  <= w_fifo_ack || w_reg_rd;
      r_pop  <= w_pop;
      r_push <= w_push;
      if (w_fifo_ack) r_rdata <= w_fifo_rdata;
      else if (w_reg_rd) r_rdata <= w_rd_mux;
      if (w_req && io_bus.i_write && io_bus.i_address[4]) r_tx_data <= w_d;
    end
  end

  sd_irq_ctrl u_irq (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_cmd_busy     (w_cmd_busy),
    .i_cmd_timeout  (i_command_status[7]),
    .i_cmd_crc      (i_command_status[8]),
    .i_dat_busy     (w_dat_busy),
    .i_dat_err      (i_dat_status[1] | i_dat_status[3]),
    .i_dma_busy     (w_dma_busy),
    .i_fifo_timeout (w_fifo_to),
    .i_wr_reject    (w_reject),
    .i_status_wr    (w_reg_wr && (w_idx == REG_IRQ_STATUS)),
    .i_mask_wr      (w_reg_wr && (w_idx == REG_IRQ_MASK)),
    .i_wdata        (w_d[7:0]),
    .o_status       (w_irq_status),
    .o_mask         (w_irq_mask),
    .o_irq          (o_irq)
  );

  assign io_bus.o_data      = r_rdata;
  assign io_bus.o_ack       = r_ack;
  assign io_bus.o_busy      = (r_state != ST_IDLE);
  assign o_sd_clk_config    = r_clk;
  assign o_command          = r_cmd;
  assign o_command_argument = r_arg;
  assign o_command_start    = r_cmd_start;
  assign o_dat_cfg          = r_dat_cfg;
  assign o_dat_start        = r_dat_start;
  assign o_dat_stop         = r_dat_stop;
  assign o_fifo_flush       = r_flush;
  assign o_rx_fifo_pop      = r_pop;
  assign o_tx_fifo_push     = r_push;
  assign o_tx_fifo_data     = r_tx_data;
  assign o_dma_bank_address = r_dma_addr;
  assign o_dma_length       = r_dma_len;
  assign o_dma_load         = r_dma_load;
  assign o_dma_ctrl         = {r_dma_dir, r_dma_stop, r_dma_start};

endmodule
